mem_stage_async: RTL
====================

Name: mem_stage_async

Overview:
- Successor MEM stage for the 5-stage pipeline, between EXE and WB.
- Unlike the fixed one-cycle stage, it waits a variable number of cycles for data-SRAM read responses (data_ok) and buffers early responses while WB stalls.
- Drops stale responses after a WB exception flush.
- Performs byte/half/word/LWL/LWR load extraction and drives forwarding, including a "result not ready" flag.

Parameters:
- PASS_W, 48: width of opaque sideband (cp0 addr, mtc0_we, ex, excode, etc.) carried EXE→WB unchanged.
- MAX_PEND, 3: maximum responses that can be cancelled; sets cancel counter width to clog2(MAX_PEND+1).

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- es_to_ms_valid  in  1  EXE has an instruction.
- ms_allowin  out  1  MEM accepts this cycle.
- es_pc  in  32  instruction PC.
- es_alu_result  in  32  ALU result / memory address.
- es_rt_value  in  32  rt value for LWL/LWR merge.
- es_load_op  in  3  000 none, 001 byte, 010 half, 011 word, 100 lwl, 101 lwr.
- es_load_sign  in  1  sign-extend byte/half.
- es_mem_req  in  1  EXE issued a read request whose response MEM must consume.
- es_gr_we  in  1  GPR write enable.
- es_dest  in  5  destination register.
- es_pass  in  PASS_W  sideband.
- data_sram_data_ok  in  1  read response valid; responses arrive in order.
- data_sram_rdata  in  32  response data.
- ex_from_ws  in  1  flush.
- ws_allowin  in  1  WB accepts.
- ms_to_ws_valid  out  1  result valid to WB.
- ms_pc  out  32  PC to WB.
- ms_final_result  out  32  result to WB.
- ms_gr_we  out  1  write enable to WB.
- ms_dest  out  5  destination to WB.
- ms_pass  out  PASS_W  sideband to WB.
- ms_fwd_valid  out  1  = ms_valid && ms_gr_we.
- ms_fwd_dest  out  5  forwarding destination.
- ms_fwd_result  out  32  = ms_final_result.
- ms_fwd_blocked  out  1  ms_valid && mem_req_r && !ms_ready_go; consumer must stall.

Behaviour:
- Reset (resetn=0 at clock edge): ms_valid=0, buf_valid=0, cancel_cnt=0. Therefore ms_to_ws_valid, ms_fwd_valid and ms_fwd_blocked are 0. Data registers are don't-care.
- Reset mid-wait discards everything; pending responses are not tracked after reset.
- Handshake:
  - ms_ready_go = !mem_req_r || buf_valid || (data_ok && cancel_cnt==0).
  - ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
  - ms_to_ws_valid = ms_valid && ms_ready_go && !ex_from_ws.
  - Input fields are latched when es_to_ms_valid && ms_allowin.
  - ms_valid <= es_to_ms_valid when ms_allowin, unless flushed.
- Response routing, in priority order:
  1. data_ok && cancel_cnt>0: dropped; cancel_cnt decrements.
  2. data_ok && ms_valid && mem_req_r && !buf_valid && !ex_from_ws: consumed.
     - If the instruction leaves this cycle (ws_allowin), data is used combinationally.
     - Otherwise rdata is latched into buf, and buf_valid<=1.
  3. Any other data_ok is a protocol error (assertion).
- buf_valid clears when the instruction leaves MEM or on flush.
- Load data source: buf_valid ? buf : data_sram_rdata.
- Flush (ex_from_ws=1): ms_valid<=0, buf_valid<=0. cancel_cnt increments by:
  - +1 if ms_valid && mem_req_r && !buf_valid && !data_ok this cycle;
  - +1 if es_to_ms_valid && es_mem_req (EXE flushed by WB as well);
  - −1 if a data_ok is dropped this cycle under case 1.
  - All three may occur simultaneously; net update is applied.
- Assertion: cancel_cnt never exceeds MAX_PEND. While cancel_cnt>0, new loads still enter MEM and wait behind the cancelled responses.
- Load extraction (a = alu_result[1:0], d = load data, rt = rt_value):
  - byte: select d[8a+7:8a], sign/zero extend.
  - half: d[31:16] if a[1], else d[15:0]; sign/zero extend.
  - word: d.
  - lwl, a=0/1/2/3: {d[7:0],rt[23:0]} / {d[15:0],rt[15:0]} / {d[23:0],rt[7:0]} / d.
  - lwr, a=0/1/2/3: d / {rt[31:24],d[31:8]} / {rt[31:16],d[31:16]} / {rt[31:8],d[31:24]}.
  - none: alu_result.
- Latency:
  - Non-load: 1 cycle in MEM.
  - Load: max(1, cycles until data_ok).

Test Plan:
1. lb signed, alu_result=0x1003, data_ok same cycle, rdata=0x80112233 → ms_final_result=0xFFFFFF80; ms_to_ws_valid 1 cycle after entry.
2. lwl, a=1, rdata=0xAABBCCDD, rt=0x11223344 → 0xCCDD3344. lwr, a=1, same data → 0x11AABBCC. lhu, a=2 → 0x0000AABB.
3. lw with data_ok delayed 3 cycles → ms_allowin=0 and ms_fwd_blocked=1 for 3 cycles; result valid on the data_ok cycle.
4. ws_allowin=0 when data_ok arrives with rdata=0x12345678, then rdata bus changes to garbage; ws_allowin=1 two cycles later → WB receives 0x12345678; buf_valid clears.
5. Flush with MEM waiting and EXE holding a load (cancel_cnt→2); next load enters → first two data_ok (0xDEAD0001, 0xDEAD0002) dropped; third, 0x0000CAFE, delivered; cancel_cnt=0.
6. resetn=0 for one cycle while a load waits → all valids 0 next cycle; ms_allowin=1.

Source files
------------

// File: rtl/mem_stage_async_if.sv
// +----------------------------------------------------------------------+
// | mem_stage_async_if : EXE/SRAM/WB-facing signal bundle of the MEM stage |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_stage_async_if #(
  parameter int PASS_W = 48
);
  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic [31:0]       es_pc;
  logic [31:0]       es_alu_result;
  logic [31:0]       es_rt_value;
  logic [2:0]        es_load_op;
  logic              es_load_sign;
  logic              es_mem_req;
  logic              es_gr_we;
  logic [4:0]        es_dest;
  logic [PASS_W-1:0] es_pass;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              ex_from_ws;
  logic              ws_allowin;
  logic              ms_to_ws_valid;
  logic [31:0]       ms_pc;
  logic [31:0]       ms_final_result;
  logic              ms_gr_we;
  logic [4:0]        ms_dest;
  logic [PASS_W-1:0] ms_pass;
  logic              ms_fwd_valid;
  logic [4:0]        ms_fwd_dest;
  logic [31:0]       ms_fwd_result;
  logic              ms_fwd_blocked;

  modport slave (
    input  es_to_ms_valid, es_pc, es_alu_result, es_rt_value, es_load_op,
           es_load_sign, es_mem_req, es_gr_we, es_dest, es_pass,
           data_sram_data_ok, data_sram_rdata, ex_from_ws, ws_allowin,
    output ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_gr_we,
           ms_dest, ms_pass, ms_fwd_valid, ms_fwd_dest, ms_fwd_result,
           ms_fwd_blocked
  );

  modport master (
    output es_to_ms_valid, es_pc, es_alu_result, es_rt_value, es_load_op,
           es_load_sign, es_mem_req, es_gr_we, es_dest, es_pass,
           data_sram_data_ok, data_sram_rdata, ex_from_ws, ws_allowin,
    input  ms_allowin, ms_to_ws_valid, ms_pc, ms_final_result, ms_gr_we,
           ms_dest, ms_pass, ms_fwd_valid, ms_fwd_dest, ms_fwd_result,
           ms_fwd_blocked
  );
endinterface

`default_nettype wire

// File: rtl/mem_stage_async.sv
// +----------------------------------------------------------------------+
// | mem_stage_async : MEM stage waiting on in-order SRAM read responses    |
// | Revision: 1.0                                                          |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_stage_async #(
  parameter int PASS_W   = 48,
  parameter int MAX_PEND = 3
) (
  input  wire logic          clk,
  input  wire logic          resetn,
  mem_stage_async_if.slave   bus
);
  localparam int CNT_W = $clog2(MAX_PEND + 1);

  logic              ms_valid_q;
  logic              buf_valid_q;
  logic [31:0]       buf_q;
  logic [CNT_W-1:0]  cancel_cnt_q;
  logic [CNT_W-1:0]  cancel_cnt_d;
  logic [CNT_W:0]    cancel_sum;
  logic [31:0]       pc_q;
  logic [31:0]       alu_q;
  logic [31:0]       rt_q;
  logic [2:0]        load_op_q;
  logic              load_sign_q;
  logic              mem_req_q;
  logic              gr_we_q;
  logic [4:0]        dest_q;
  logic [PASS_W-1:0] pass_q;

  logic        flush, drop, own_ok, ready_go, allowin, consume, leave;
  logic        inc_mem, inc_exe;
  logic [31:0] ld_data, result;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [1:0]  a;

  assign flush    = bus.ex_from_ws;
  assign drop     = bus.data_sram_data_ok && (cancel_cnt_q != '0);
  assign own_ok   = bus.data_sram_data_ok && (cancel_cnt_q == '0);
  assign ready_go = !mem_req_q || buf_valid_q || own_ok;
  assign allowin  = !ms_valid_q || (ready_go && bus.ws_allowin);
  assign consume  = own_ok && ms_valid_q && mem_req_q && !buf_valid_q && !flush;
  assign leave    = ms_valid_q && ready_go && bus.ws_allowin;

  // Responses still owed to instructions killed by this flush.
  assign inc_mem = flush && ms_valid_q && mem_req_q && !buf_valid_q && !own_ok;
  assign inc_exe = flush && bus.es_to_ms_valid && bus.es_mem_req;

  always_comb begin
    cancel_sum = {1'b0, cancel_cnt_q};
    if (inc_mem) cancel_sum = cancel_sum + {{CNT_W{1'b0}}, 1'b1};
    if (inc_exe) cancel_sum = cancel_sum + {{CNT_W{1'b0}}, 1'b1};
    if (drop)    cancel_sum = cancel_sum - {{CNT_W{1'b0}}, 1'b1};
    cancel_cnt_d = cancel_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ms_valid_q   <= 1'b0;
      buf_valid_q  <= 1'b0;
      cancel_cnt_q <= '0;
    end else begin
      cancel_cnt_q <= cancel_cnt_d;
      if (flush)        ms_valid_q <= 1'b0;
      else if (allowin) ms_valid_q <= bus.es_to_ms_valid;
      if (flush || leave) buf_valid_q <= 1'b0;
      else if (consume)   buf_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (bus.es_to_ms_valid && allowin) begin
      pc_q        <= bus.es_pc;
      alu_q       <= bus.es_alu_result;
      rt_q        <= bus.es_rt_value;
      load_op_q   <= bus.es_load_op;
      load_sign_q <= bus.es_load_sign;
      mem_req_q   <= bus.es_mem_req;
      gr_we_q     <= bus.es_gr_we;
      dest_q      <= bus.es_dest;
      pass_q      <= bus.es_pass;
    end
    if (consume && !bus.ws_allowin) buf_q <= bus.data_sram_rdata;
  end

  assign ld_data  = buf_valid_q ? buf_q : bus.data_sram_rdata;
  assign a        = alu_q[1:0];
  assign byte_sel = ld_data[{a, 3'b000} +: 8];
  assign half_sel = a[1] ? ld_data[31:16] : ld_data[15:0];

  always_comb begin
    result = alu_q;
    case (load_op_q)
      3'b001: result = {{24{load_sign_q & byte_sel[7]}}, byte_sel};
      3'b010: result = {{16{load_sign_q & half_sel[15]}}, half_sel};
      3'b011: result = ld_data;
      3'b100: begin
        case (a)
          2'd0:    result = {ld_data[7:0],  rt_q[23:0]};
          2'd1:    result = {ld_data[15:0], rt_q[15:0]};
          2'd2:    result = {ld_data[23:0], rt_q[7:0]};
          default: result = ld_data;
        endcase
      end
      3'b101: begin
        case (a)
          2'd0:    result = ld_data;
          2'd1:    result = {rt_q[31:24], ld_data[31:8]};
          2'd2:    result = {rt_q[31:16], ld_data[31:16]};
          default: result = {rt_q[31:8],  ld_data[31:24]};
        endcase
      end
      default: result = alu_q;
    endcase
  end

  assign bus.ms_allowin      = allowin;
  assign bus.ms_to_ws_valid  = ms_valid_q && ready_go && !flush;
  assign bus.ms_pc           = pc_q;
  assign bus.ms_final_result = result;
  assign bus.ms_gr_we        = gr_we_q;
  assign bus.ms_dest         = dest_q;
  assign bus.ms_pass         = pass_q;
  assign bus.ms_fwd_valid    = ms_valid_q && gr_we_q;
  assign bus.ms_fwd_dest     = dest_q;
  assign bus.ms_fwd_result   = result;
  assign bus.ms_fwd_blocked  = ms_valid_q && mem_req_q && !ready_go;

  // A response must either be cancelled or belong to the waiting load.
  a_resp_owner: assert property (@(posedge clk) disable iff (!resetn)
    bus.data_sram_data_ok |-> (cancel_cnt_q != '0) ||
                              (ms_valid_q && mem_req_q && !buf_valid_q));
  a_cancel_max: assert property (@(posedge clk) disable iff (!resetn)
    int'(cancel_sum) <= MAX_PEND);

endmodule

`default_nettype wire
